// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_pkg
//  Description : Shared encodings for the Gray sequencer: FSM state codes
//                (IDLE, RUN) and run-mode codes (one-shot, continuous).
//  Revision    : 1.0  initial release
// ============================================================================
package gray_pkg;

    localparam int C_STATE_W = 1;

    localparam logic [C_STATE_W-1:0] C_ST_IDLE = 1'b0;
    localparam logic [C_STATE_W-1:0] C_ST_RUN  = 1'b1;

    localparam logic C_MODE_ONESHOT = 1'b0;
    localparam logic C_MODE_CONT    = 1'b1;

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray_cnt_core.sv
`default_nettype none
// ============================================================================
//  Module      : gray_cnt_core
//  Description : N-bit binary counter with a registered Gray-coded copy.
//                clr has priority over en; both outputs update together so
//                gray_out always equals bin ^ (bin >> 1).
//  Ports       : clk, rst (sync, active-high)
//                clr      - zero the count
//                en       - advance the count by one (wraps modulo 2^N)
//                bin      - binary count
//                gray_out - Gray code of bin
//  Revision    : 1.0  initial release
// ============================================================================
module gray_cnt_core #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [N-1:0] bin,
    output logic [N-1:0] gray_out
);

    logic [N-1:0] w_bin_nxt;

    always_comb begin
        w_bin_nxt = bin;
        if (clr) begin
            w_bin_nxt = '0;
        end else if (en) begin
            w_bin_nxt = bin + N'(1);
        end
    end

    // Gray is computed from the next binary value so both registers stay
    // aligned in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin      <= '0;
            gray_out <= '0;
        end else begin
            bin      <= w_bin_nxt;
            gray_out <= w_bin_nxt ^ (w_bin_nxt >> 1);
        end
    end

endmodule : gray_cnt_core
`default_nettype wire

// File: rtl/gray_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gray_seq_ctrl
//  Description : Two-state (IDLE/RUN) sequencer stepping a Gray counter at a
//                programmable period of presc+1 clocks, in one-shot (len
//                steps) or continuous mode. All outputs are registered.
//  Ports       : clk, rst (sync, active-high)
//                start, stop    - run / abort requests (stop wins)
//                mode, len, presc - captured when start is accepted
//                gray_out       - current Gray value
//                step           - pulse in the cycle gray_out changes
//                busy           - high while in RUN
//                done           - pulse when a one-shot run completes
//  Revision    : 1.0  initial release
// ============================================================================
module gray_seq_ctrl
    import gray_pkg::*;
#(
    parameter int N       = 4,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [N-1:0]       len,
    input  logic [PRESC_W-1:0] presc,
    output logic [N-1:0]       gray_out,
    output logic               step,
    output logic               busy,
    output logic               done
);

    logic [C_STATE_W-1:0] r_state;
    logic                 r_mode;
    logic [N-1:0]         r_len;
    logic [PRESC_W-1:0]   r_presc;
    logic [PRESC_W-1:0]   r_pcnt;
    logic                 r_step;
    logic                 r_done;

    logic [N-1:0]         w_bin;
    logic                 w_run;
    logic                 w_accept;
    logic                 w_tick;
    logic                 w_zero_len;
    logic                 w_adv;
    logic                 w_last;

    always_comb begin
        w_run      = (r_state == C_ST_RUN) && !stop;
        w_accept   = (r_state == C_ST_IDLE) && start && !stop;
        w_tick     = w_run && (r_pcnt == r_presc);
        // A zero-length one-shot finishes after one RUN cycle without stepping.
        w_zero_len = w_run && (r_mode == C_MODE_ONESHOT) && (r_len == '0);
        w_adv      = w_tick && !w_zero_len;
        // bin equals the number of steps taken so far, so the step that makes
        // bin reach len is the final one of a one-shot run.
        w_last     = w_adv && (r_mode == C_MODE_ONESHOT) && ((w_bin + N'(1)) == r_len);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
            r_mode  <= 1'b0;
            r_len   <= '0;
            r_presc <= '0;
            r_pcnt  <= '0;
            r_step  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_step <= w_adv;
            r_done <= w_last || w_zero_len;

            case (r_state)
                C_ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= C_ST_RUN;
                        r_mode  <= mode;
                        r_len   <= len;
                        r_presc <= presc;
                        r_pcnt  <= '0;
                    end
                end
                C_ST_RUN: begin
                    if (stop || w_last || w_zero_len) begin
                        r_state <= C_ST_IDLE;
                    end
                    if (w_run) begin
                        r_pcnt <= w_tick ? '0 : r_pcnt + PRESC_W'(1);
                    end
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

    gray_cnt_core #(
        .N (N)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_accept),
        .en       (w_adv),
        .bin      (w_bin),
        .gray_out (gray_out)
    );

    assign step = r_step;
    assign done = r_done;
    assign busy = (r_state == C_ST_RUN);

endmodule : gray_seq_ctrl
`default_nettype wire

// File: tb/tb_gray_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_seq_ctrl
//  Description : Self-checking bench for gray_seq_ctrl. A reference model
//                computes expected outputs as stimulus is driven; they are
//                queued and compared after each rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gray_seq_ctrl;

    localparam int N       = 4;
    localparam int PRESC_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               stop;
    logic               mode;
    logic [N-1:0]       len;
    logic [PRESC_W-1:0] presc;
    logic [N-1:0]       gray_out;
    logic               step;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    gray_seq_ctrl #(
        .N       (N),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .len      (len),
        .presc    (presc),
        .gray_out (gray_out),
        .step     (step),
        .busy     (busy),
        .done     (done)
    );

    typedef struct packed {
        logic [N-1:0] gray;
        logic         step;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: countdown timer to the next step and number of
    // steps still owed in one-shot mode.
    logic m_run;
    logic m_mode;
    int   m_cnt;
    int   m_timer;
    int   m_presc;
    int   m_left;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] to_gray(input int b);
        logic [N-1:0] v;
        v = N'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic model_edge(input logic r, s, p, md, input logic [N-1:0] ln,
                              input logic [PRESC_W-1:0] ps, output exp_t e);
        logic st;
        logic dn;
        st = 1'b0;
        dn = 1'b0;
        if (r) begin
            m_run = 0; m_mode = 0; m_cnt = 0; m_timer = 0; m_presc = 0; m_left = 0;
        end else if (!m_run) begin
            if (s && !p) begin
                m_run   = 1;
                m_mode  = md;
                m_cnt   = 0;
                m_presc = int'(ps);
                m_timer = int'(ps);
                m_left  = int'(ln);
            end
        end else if (p) begin
            m_run = 0;
        end else if (!m_mode && m_left == 0) begin
            m_run = 0;
            dn    = 1'b1;
        end else if (m_timer == 0) begin
            m_cnt   = (m_cnt + 1) % (1 << N);
            m_timer = m_presc;
            st      = 1'b1;
            if (!m_mode) begin
                m_left--;
                if (m_left == 0) begin
                    m_run = 0;
                    dn    = 1'b1;
                end
            end
        end else begin
            m_timer--;
        end
        e.gray = to_gray(m_cnt);
        e.step = st;
        e.busy = m_run;
        e.done = dn;
    endtask

    task automatic cyc(input logic r, s, p, md, input logic [N-1:0] ln,
                       input logic [PRESC_W-1:0] ps);
        exp_t e;
        rst = r; start = s; stop = p; mode = md; len = ln; presc = ps;
        model_edge(r, s, p, md, ln, ps, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("gray", 32'(gray_out), 32'(e.gray));
            check("step", 32'(step), 32'(e.step));
            check("busy", 32'(busy), 32'(e.busy));
            check("done", 32'(done), 32'(e.done));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] tbl [3];
        logic [N-1:0] prev;
        int           nstep;
        tbl[0] = 4'b0001; tbl[1] = 4'b0011; tbl[2] = 4'b0010;

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 8'hFF);
        check("rst_gray", 32'(gray_out), 32'd0);

        // One-shot len=3 presc=0, start on the first edge after reset
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 8'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            check("oneshot_gray", 32'(gray_out), 32'(tbl[i]));
        end
        check("oneshot_done", 32'(done), 32'd1);
        check("oneshot_busy", 32'(busy), 32'd0);
        idle(3);
        check("idle_hold", 32'(gray_out), 32'b0010);

        // Continuous presc=2: 16 steps in 48 clocks, wraps to 0000
        cyc(1'b0, 1'b1, 1'b0, 1'b1, '0, 8'd2);
        prev  = gray_out;
        nstep = 0;
        for (int i = 0; i < 48; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            if (step) begin
                nstep++;
                check("one_bit", 32'($countones(gray_out ^ prev)), 32'd1);
                prev = gray_out;
            end
        end
        check("cont_steps", 32'(nstep), 32'd16);
        check("cont_wrap", 32'(gray_out), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);

        // One-shot len=0
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd3);
        check("len0_busy", 32'(busy), 32'd1);
        idle(3);

        // Continuous presc=0, stop at 0110, then restart
        cyc(1'b0, 1'b1, 1'b0, 1'b1, '0, 8'd0);
        idle(4);
        check("at_0110", 32'(gray_out), 32'b0110);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        check("stop_hold", 32'(gray_out), 32'b0110);
        idle(2);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, '0, 8'd1);
        check("restart_clr", 32'(gray_out), 32'd0);
        idle(5);

        // Reset mid-run then immediate start
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 8'd1);
        idle(6);

        // start+stop in IDLE, start during RUN, stop on terminal step
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 8'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 8'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 8'd0);
        idle(8);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
        idle(2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                N'($urandom_range(0, 5)), PRESC_W'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_gray_seq_ctrl
`default_nettype wire
